// File: rtl/sound_rom_pkg.sv
// ============================================================================
// Package : sound_rom_pkg
// Sound ROM memory map and the state encoding of the ROM arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package sound_rom_pkg;

  // ROM map: where each table of the sound ROM starts
  localparam logic [7:0] NOTE_VALUE_BASE         = 8'h00;
  localparam logic [7:0] INSTRUMENT_LENGTHS_BASE = 8'h80;
  localparam logic [7:0] INSTRUMENT_VALUES_BASE  = 8'h84;

  // Arbiter states
  localparam logic [0:0] ARB    = 1'b0;
  localparam logic [0:0] LOCKED = 1'b1;

endpackage

`default_nettype wire

// File: rtl/rom_arbiter_if.sv
// ============================================================================
// Interface : rom_arbiter_if
// Voice-side req/gnt/rvalid bus plus the raw ROM port of the ROM arbiter.
// The master modport is the environment (voices and ROM), the slave modport
// is the arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

interface rom_arbiter_if #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16
);
  logic [NUM_PORTS-1:0]        i_req;
  logic [NUM_PORTS-1:0]        i_lock;
  logic [NUM_PORTS*ADDR_W-1:0] i_addr;
  logic [NUM_PORTS-1:0]        o_gnt;
  logic [NUM_PORTS-1:0]        o_rvalid;
  logic [DATA_W-1:0]           o_rdata;
  logic [ADDR_W-1:0]           o_rom_addr;
  logic [DATA_W-1:0]           i_rom_data;

  modport master (
    output i_req, i_lock, i_addr, i_rom_data,
    input  o_gnt, o_rvalid, o_rdata, o_rom_addr
  );

  modport slave (
    input  i_req, i_lock, i_addr, i_rom_data,
    output o_gnt, o_rvalid, o_rdata, o_rom_addr
  );
endinterface

`default_nettype wire

// File: rtl/rom_arbiter_rr_picker.sv
// ============================================================================
// Module  : rr_picker
// Combinational find-first-set starting at a rotating pointer.
// Returns a one-hot grant, its binary index and a found flag.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_picker #(
  parameter int NUM_PORTS = 4,
  localparam int IDX_W    = $clog2(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IDX_W-1:0]     ptr,
  output logic [NUM_PORTS-1:0] gnt,
  output logic [IDX_W-1:0]     idx,
  output logic                 found
);

  logic [IDX_W-1:0] k;

  // Walk ptr, ptr+1, ... (mod NUM_PORTS) and take the first requester
  always_comb begin
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    k     = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      k = IDX_W'((int'(ptr) + i) % NUM_PORTS);
      if (!found && req[k]) begin
        found  = 1'b1;
        gnt[k] = 1'b1;
        idx    = k;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/rom_arbiter.sv
// ============================================================================
// Module  : rom_arbiter
// Round-robin arbiter sharing one synchronous sound ROM between voices.
// One grant per cycle; read data returns to the winner one cycle later.
// Optional burst lock enabled by defining ROM_ARB_LOCK_EN.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rom_arbiter
  import sound_rom_pkg::*;
#(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W    = 8,
  parameter int DATA_W    = 16,
  parameter int MAX_LOCK  = 4
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  rom_arbiter_if.slave bus
);

  localparam int IDX_W = $clog2(NUM_PORTS);

  logic [IDX_W-1:0]     prio_ptr;
  logic [NUM_PORTS-1:0] rvalid_q;
  logic [NUM_PORTS-1:0] pick_gnt;
  logic [IDX_W-1:0]     pick_idx;
  logic                 pick_found;
  logic [NUM_PORTS-1:0] gnt;
  logic [IDX_W-1:0]     win_idx;
  logic                 any_gnt;
  logic [ADDR_W-1:0]    rom_addr;

  rr_picker #(.NUM_PORTS(NUM_PORTS)) u_picker (
    .req   (bus.i_req),
    .ptr   (prio_ptr),
    .gnt   (pick_gnt),
    .idx   (pick_idx),
    .found (pick_found)
  );

`ifdef ROM_ARB_LOCK_EN
  localparam int CNT_W = $clog2(MAX_LOCK + 1);

  logic [0:0]       state;
  logic [IDX_W-1:0] owner;
  logic [CNT_W-1:0] lock_cnt;
  logic             hold;

  // The owner keeps the ROM while it still locks, requests and has budget left
  always_comb begin
    hold = (state == LOCKED) && bus.i_lock[owner] && bus.i_req[owner] &&
           (lock_cnt != CNT_W'(MAX_LOCK));
  end

  // Locked owner bypasses round-robin; otherwise the picker decides
  always_comb begin
    gnt     = pick_gnt;
    win_idx = pick_idx;
    any_gnt = pick_found;
    if (hold) begin
      gnt        = '0;
      gnt[owner] = 1'b1;
      win_idx    = owner;
      any_gnt    = 1'b1;
    end
    if (!i_rst_n) begin
      gnt     = '0;
      any_gnt = 1'b0;
    end
  end

  // Lock FSM: enter on a locked grant, leave when the burst ends or hits MAX_LOCK
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state    <= ARB;
      owner    <= '0;
      lock_cnt <= '0;
    end else if (hold) begin
      lock_cnt <= lock_cnt + CNT_W'(1);
    end else if (any_gnt && bus.i_lock[win_idx]) begin
      state    <= LOCKED;
      owner    <= win_idx;
      lock_cnt <= CNT_W'(1);
    end else begin
      state    <= ARB;
      lock_cnt <= '0;
    end
  end
`else
  logic unused_lock;
  assign unused_lock = ^bus.i_lock;

  // Plain round-robin; no grants while reset is asserted
  always_comb begin
    gnt     = i_rst_n ? pick_gnt : '0;
    win_idx = pick_idx;
    any_gnt = i_rst_n & pick_found;
  end
`endif

  // Rotate priority to just past the winner; hold it when nobody is granted
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      prio_ptr <= '0;
    end else if (any_gnt) begin
      prio_ptr <= (win_idx == IDX_W'(NUM_PORTS - 1)) ? '0 : win_idx + IDX_W'(1);
    end
  end

  // ROM data arrives one cycle after the address, so rvalid is gnt delayed
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      rvalid_q <= '0;
    end else begin
      rvalid_q <= gnt;
    end
  end

  // Address mux driven by the one-hot grant; zero when idle
  always_comb begin
    rom_addr = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (gnt[p]) begin
        rom_addr = rom_addr | bus.i_addr[p*ADDR_W +: ADDR_W];
      end
    end
  end

  assign bus.o_gnt      = gnt;
  assign bus.o_rvalid   = rvalid_q;
  assign bus.o_rdata    = bus.i_rom_data;
  assign bus.o_rom_addr = rom_addr;

endmodule

`default_nettype wire
